// File: rtl/mem_ext_pkg.sv
// mem_ext_pkg: shared constants, FSM state type and write-mask helper for the *_ext memory macros.
package mem_ext_pkg;
  localparam int RDW_NEW_DATA = 0;
  localparam int RDW_OLD_DATA = 1;
  localparam int MAX_LANES = 256;
  localparam int LANE_IW = 8;
  localparam logic [63:0] LFSR_SEED = 64'h1;
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;
  typedef enum logic {INIT, READY} state_e;
  function automatic logic lane_bit(input logic [MAX_LANES-1:0] mask, input int b, input int gran);
    return mask[LANE_IW'(b / gran)];
  endfunction
endpackage

// File: rtl/mem_init_seq.sv
// mem_init_seq: post-reset init sweep counter and INIT/READY state machine.
module mem_init_seq
  import mem_ext_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr,
  output logic              init_busy
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  state_e state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic last;
  always_ff @(posedge clock)
    if (reset) begin
      state <= INIT;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  always_comb begin
    last = cnt == LAST;
    state_nxt = (state == INIT && last) ? READY : state;
    cnt_nxt = (state != INIT) ? cnt : last ? '0 : cnt + 1'b1;
  end
  assign init_we = state == INIT;
  assign init_busy = state == INIT;
  assign init_addr = cnt;
endmodule

// File: rtl/mem_1r1w_init_ext.sv
// mem_1r1w_init_ext: behavioural 1R1W SRAM with init sweep, RDW select and read-valid.
// MEM_GARBAGE_OUT_EN: when defined, R0_data shows an LFSR pattern whenever R0_valid is low.
module mem_1r1w_init_ext
  import mem_ext_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int DATA_W = 64,
  parameter int MASK_GRAN = 8,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0,
  parameter int RDW_MODE = RDW_NEW_DATA,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int LANES = DATA_W / MASK_GRAN
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              W0_en,
  input  logic [ADDR_W-1:0] W0_addr,
  input  logic [DATA_W-1:0] W0_data,
  input  logic [LANES-1:0]  W0_mask,
  input  logic              R0_en,
  input  logic [ADDR_W-1:0] R0_addr,
  output logic [DATA_W-1:0] R0_data,
  output logic              R0_valid,
  output logic              init_busy
);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
  if (DATA_W % MASK_GRAN != 0) begin : g_bad_gran
    $error("MASK_GRAN must divide DATA_W");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("DEPTH must be at least 2");
  end
  if (LANES > MAX_LANES) begin : g_bad_lanes
    $error("too many write-mask lanes");
  end
  if (RDW_MODE != RDW_NEW_DATA && RDW_MODE != RDW_OLD_DATA) begin : g_bad_rdw
    $error("RDW_MODE must be 0 or 1");
  end
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] bit_mask, wr_old, wr_word, rd_old, rd_word, rd_q;
  logic [ADDR_W-1:0] init_addr;
  logic init_we, wr_in, rd_in, wr_go, rd_go, rdw_hit, rd_v;
  mem_init_seq #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_seq (
    .clock(clock),
    .reset(reset),
    .init_we(init_we),
    .init_addr(init_addr),
    .init_busy(init_busy)
  );
  always_comb
    for (int b = 0; b < DATA_W; b++) bit_mask[b] = lane_bit(MAX_LANES'(W0_mask), b, MASK_GRAN);
  // Out-of-range addresses never touch the array; a non-power-of-two DEPTH must not alias.
  always_comb begin
    wr_in = {1'b0, W0_addr} < DEPTH_X;
    rd_in = {1'b0, R0_addr} < DEPTH_X;
    wr_go = !reset && !init_busy && W0_en && wr_in;
    rd_go = !reset && !init_busy && R0_en;
    wr_old = wr_in ? mem[W0_addr] : '0;
    rd_old = rd_in ? mem[R0_addr] : '0;
    wr_word = (wr_old & ~bit_mask) | (W0_data & bit_mask);
    rdw_hit = W0_en && W0_addr == R0_addr;
    rd_word = !rd_in ? '0 : (RDW_MODE == RDW_NEW_DATA && rdw_hit) ? wr_word : rd_old;
  end
  always_ff @(posedge clock)
    if (init_we) mem[init_addr] <= INIT_VALUE;
    else if (wr_go) mem[W0_addr] <= wr_word;
  always_ff @(posedge clock)
    if (reset) begin
      rd_v <= 1'b0;
      rd_q <= '0;
    end else begin
      rd_v <= rd_go;
      if (rd_go) rd_q <= rd_word;
    end
  assign R0_valid = rd_v;
`ifdef MEM_GARBAGE_OUT_EN
  logic [63:0] lfsr;
  logic [DATA_W-1:0] garbage;
  always_ff @(posedge clock)
    lfsr <= reset ? LFSR_SEED : (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 64'h0);
  always_comb
    for (int b = 0; b < DATA_W; b++) garbage[b] = lfsr[6'(b % 64)];
  assign R0_data = rd_v ? rd_q : garbage;
`else
  assign R0_data = rd_q;
`endif
endmodule

// File: tb/tb_mem_1r1w_init_ext.sv
// tb_mem_1r1w_init_ext: scoreboard bench driving a new-data and an old-data RDW instance in lockstep.
module tb_mem_1r1w_init_ext;
  localparam logic [31:0] IV = 32'hA5A5A5A5;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic W0_en = 1'b0, R0_en = 1'b0;
  logic [4:0] W0_addr = '0, R0_addr = '0;
  logic [31:0] W0_data = '0;
  logic [3:0] W0_mask = '0;
  logic [31:0] rd_d [2];
  logic rd_v [2];
  logic busy [2];
  logic [31:0] q [2][$];
  logic [31:0] hold [2];
  logic mon_on = 1'b0;
  int n_vec = 0, n_bad = 0;
  always #5 clock = ~clock;

  mem_1r1w_init_ext #(.DEPTH(20), .DATA_W(32), .MASK_GRAN(8), .INIT_VALUE(IV), .RDW_MODE(0)) u_new (
    .clock(clock), .reset(reset), .W0_en(W0_en), .W0_addr(W0_addr), .W0_data(W0_data),
    .W0_mask(W0_mask), .R0_en(R0_en), .R0_addr(R0_addr), .R0_data(rd_d[0]),
    .R0_valid(rd_v[0]), .init_busy(busy[0]));
  mem_1r1w_init_ext #(.DEPTH(20), .DATA_W(32), .MASK_GRAN(8), .INIT_VALUE(IV), .RDW_MODE(1)) u_old (
    .clock(clock), .reset(reset), .W0_en(W0_en), .W0_addr(W0_addr), .W0_data(W0_data),
    .W0_mask(W0_mask), .R0_en(R0_en), .R0_addr(R0_addr), .R0_data(rd_d[1]),
    .R0_valid(rd_v[1]), .init_busy(busy[1]));

`ifdef MEM_GARBAGE_OUT_EN
  logic [63:0] lfsr;
  always @(posedge clock)
    lfsr <= reset ? 64'h1 : {1'b0, lfsr[63:1]} ^ (lfsr[0] ? 64'hD800000000000000 : 64'h0);
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Monitor: pops on every valid, otherwise checks what idle R0_data must show.
  always @(negedge clock)
    if (mon_on)
      for (int k = 0; k < 2; k++) begin
        if (rd_v[k]) begin
          if (q[k].size() == 0) check($sformatf("spurious_valid%0d", k), rd_d[k], 32'hx);
          else begin
            hold[k] = q[k].pop_front();
            check($sformatf("read%0d", k), rd_d[k], hold[k]);
          end
        end else begin
`ifdef MEM_GARBAGE_OUT_EN
          check($sformatf("garbage%0d", k), rd_d[k], lfsr[31:0]);
`else
          check($sformatf("hold%0d", k), rd_d[k], hold[k]);
`endif
        end
        if (reset) begin
          hold[k] = '0;
          q[k].delete();
        end
      end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic xfer(input logic we, input logic [4:0] wa, input logic [31:0] d, input logic [3:0] m,
                      input logic re, input logic [4:0] ra, input logic [31:0] e0, input logic [31:0] e1);
    W0_en = we; W0_addr = wa; W0_data = d; W0_mask = m;
    R0_en = re; R0_addr = ra;
    if (re) begin
      q[0].push_back(e0);
      q[1].push_back(e1);
    end
    step();
    W0_en = 1'b0; R0_en = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
    xfer(1'b1, a, d, m, 1'b0, '0, '0, '0);
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] e);
    xfer(1'b0, '0, '0, '0, 1'b1, a, e, e);
  endtask

  // Counts busy cycles of each instance (bounded), then drops the write held during the sweep.
  task automatic sweep(input string name);
    int c0 = 0, c1 = 0;
    for (int n = 0; n < 100 && (busy[0] || busy[1]); n++) begin
      c0 += int'(busy[0]);
      c1 += int'(busy[1]);
      step();
    end
    W0_en = 1'b0;
    check({name, "_busy_new"}, c0, 20);
    check({name, "_busy_old"}, c1, 20);
  endtask

  initial begin
    hold[0] = '0; hold[1] = '0;
    step();
    step();
    mon_on = 1'b1;
    check("rst_busy", {31'b0, busy[0]}, 1);
    check("rst_valid", {31'b0, rd_v[0]}, 0);
`ifdef MEM_GARBAGE_OUT_EN
    check("rst_data", rd_d[0], 32'h1);
`else
    check("rst_data", rd_d[0], 0);
`endif
    // init sweep with read and write requests held: both must be ignored
    W0_en = 1'b1; W0_addr = 5'd3; W0_data = 32'h0; W0_mask = 4'hF;
    R0_en = 1'b1; R0_addr = 5'd3;
    reset = 1'b0;
    sweep("init1");
    q[0].push_back(IV); q[1].push_back(IV);
    step();
    R0_en = 1'b0;
    check("ready_busy", {31'b0, busy[0]}, 0);
    wr(5'd5, 32'h11223344, 4'b0101);
    rd(5'd5, 32'hA522A544);
    xfer(1'b1, 5'd7, 32'hDEADBEEF, 4'hF, 1'b1, 5'd7, 32'hDEADBEEF, IV);
    rd(5'd7, 32'hDEADBEEF);
    xfer(1'b1, 5'd7, 32'h0, 4'h0, 1'b1, 5'd7, 32'hDEADBEEF, 32'hDEADBEEF);
    xfer(1'b1, 5'd5, 32'hFFFFFFFF, 4'b1000, 1'b1, 5'd5, 32'hFF22A544, 32'hA522A544);
    xfer(1'b1, 5'd8, 32'h12345678, 4'hF, 1'b1, 5'd7, 32'hDEADBEEF, 32'hDEADBEEF);
    rd(5'd8, 32'h12345678);
    rd(5'd5, 32'hFF22A544);
    wr(5'd25, 32'hCAFEF00D, 4'hF);
    rd(5'd25, 32'h0);
    rd(5'd5, 32'hFF22A544);
    xfer(1'b1, 5'd25, 32'h01010101, 4'hF, 1'b1, 5'd25, 32'h0, 32'h0);
    wr(5'd19, 32'h0BADCAFE, 4'hF);
    rd(5'd19, 32'h0BADCAFE);
    rd(5'd0, IV);
    repeat (2) step();
    // reset with a read in flight, then again mid-sweep
    R0_en = 1'b1; R0_addr = 5'd7; reset = 1'b1;
    step();
    reset = 1'b0;
    W0_en = 1'b1; W0_addr = 5'd3; W0_data = 32'h0; W0_mask = 4'hF;
    R0_addr = 5'd3;
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    sweep("init2");
    q[0].push_back(IV); q[1].push_back(IV);
    step();
    R0_en = 1'b0;
    rd(5'd5, IV);
    rd(5'd7, IV);
    rd(5'd8, IV);
    rd(5'd19, IV);
    wr(5'd2, 32'h11223344, 4'hF);
    rd(5'd2, 32'h11223344);
    repeat (6) step();
    check("drain_new", q[0].size(), 0);
    check("drain_old", q[1].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end
endmodule
